cpu_exec_unit: RTL

- Execute stage of the 4-bit CPU, directly downstream of the instruction decoder.
- Owns the architectural state:
  - registers A and B;
  - program counter (PC);
  - carry flag;
  - output port.
- Latches the decoded opecode/imm into an instruction register, then applies it.
- Advances one phase per `step` pulse from the board clock divider, giving a two-phase FETCH/EXEC sequence.
- PC drives the program ROM address; ROM data feeds the decoder, whose outputs return here.

---
 rtl/cpu_exec_unit_pkg.sv | 31 +++
 rtl/cpu_exec_unit_alu_add4.sv | 15 +
 rtl/cpu_exec_unit.sv | 124 ++++++++++++
 3 files changed

// File: rtl/cpu_exec_unit_pkg.sv
// rtl/cpu_exec_unit_pkg.sv - shared types for the 4-bit CPU execute stage
// Purpose: opcode encoding from the decoder, execute-stage phase enum, word type.
// Ports: none (package).
package lib_cpu;

  typedef logic [3:0] word_t;

  // Encoding 0 is INVALID so a cleared instruction register never executes.
  typedef enum logic [3:0] {
    INVALID   = 4'h0,
    MOV_A_B   = 4'h1,
    MOV_B_A   = 4'h2,
    MOV_A_IMM = 4'h3,
    MOV_B_IMM = 4'h4,
    IN_A      = 4'h5,
    IN_B      = 4'h6,
    OUT_B     = 4'h7,
    OUT_IMM   = 4'h8,
    ADD_A_IMM = 4'h9,
    ADD_B_IMM = 4'hA,
    JMP_IMM   = 4'hB,
    JNC_IMM   = 4'hC
  } OPECODE;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } EXEC_STATE;

endpackage

// File: rtl/cpu_exec_unit_alu_add4.sv
// rtl/cpu_exec_unit_alu_add4.sv - combinational 4-bit adder with carry out
// Purpose: shared adder for register-plus-immediate and program counter increment.
// Ports: a, b (4-bit operands) -> sum (4-bit), cout (carry out of bit 3).
module alu_add4
  import lib_cpu::*;
(
  input  word_t a,
  input  word_t b,
  output word_t sum,
  output logic  cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/cpu_exec_unit.sv
// rtl/cpu_exec_unit.sv - two-phase FETCH/EXEC execute stage of the 4-bit CPU
// Purpose: latches the decoded instruction on a FETCH step, applies it on the
//   following EXEC step; owns A, B, PC, carry and the output port.
// Ports: clk, rst (async, active-high); step (phase advance enable);
//   opecode/imm from decoder; in_port switches; pc (ROM address), out_port,
//   reg_a, reg_b, carry, halted observation outputs.
module cpu_exec_unit
  import lib_cpu::*;
#(
  parameter word_t RESET_PC = 4'h0
)
(
  input  logic   clk,
  input  logic   rst,
  input  logic   step,
  input  OPECODE opecode,
  input  word_t  imm,
  input  word_t  in_port,
  output word_t  pc,
  output word_t  out_port,
  output word_t  reg_a,
  output word_t  reg_b,
  output logic   carry,
  output logic   halted
);

  EXEC_STATE state_q;
  OPECODE    ir_op_q;
  word_t     ir_imm_q;
  word_t     pc_q;
  word_t     a_q;
  word_t     b_q;
  word_t     out_q;
  logic      carry_q;
  logic      halted_q;

  word_t     add_src;
  word_t     add_sum;
  logic      add_cout;
  word_t     pc_inc;
  logic      pc_cout_unused;

  // Only ADD_B_IMM adds to B; every other use of the adder is A + imm.
  assign add_src = (ir_op_q == ADD_B_IMM) ? b_q : a_q;

  alu_add4 u_add_imm (
    .a    (add_src),
    .b    (ir_imm_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // PC wraps naturally at 4 bits; the carry out is deliberately discarded.
  alu_add4 u_pc_inc (
    .a    (pc_q),
    .b    (4'd1),
    .sum  (pc_inc),
    .cout (pc_cout_unused)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FETCH;
      ir_op_q  <= INVALID;
      ir_imm_q <= '0;
      pc_q     <= RESET_PC;
      a_q      <= '0;
      b_q      <= '0;
      out_q    <= '0;
      carry_q  <= 1'b0;
      halted_q <= 1'b0;
    end else if (step) begin
      case (state_q)
        FETCH: begin
          ir_op_q  <= opecode;
          ir_imm_q <= imm;
          state_q  <= EXEC;
        end
        EXEC: begin
          // Default effect of every valid instruction; overridden below.
          state_q <= FETCH;
          pc_q    <= pc_inc;
          carry_q <= 1'b0;
          case (ir_op_q)
            MOV_A_B:   a_q   <= b_q;
            MOV_B_A:   b_q   <= a_q;
            MOV_A_IMM: a_q   <= ir_imm_q;
            MOV_B_IMM: b_q   <= ir_imm_q;
            IN_A:      a_q   <= in_port;
            IN_B:      b_q   <= in_port;
            OUT_B:     out_q <= b_q;
            OUT_IMM:   out_q <= ir_imm_q;
            ADD_A_IMM: {carry_q, a_q} <= {add_cout, add_sum};
            ADD_B_IMM: {carry_q, b_q} <= {add_cout, add_sum};
            JMP_IMM:   pc_q  <= ir_imm_q;
            JNC_IMM:   if (!carry_q) pc_q <= ir_imm_q;
            default: begin
              // INVALID and unused encodings freeze the machine untouched.
              state_q  <= HALT;
              halted_q <= 1'b1;
              pc_q     <= pc_q;
              carry_q  <= carry_q;
            end
          endcase
        end
        HALT: begin
          state_q <= HALT;
        end
        default: begin
          state_q  <= HALT;
          halted_q <= 1'b1;
        end
      endcase
    end
  end

  assign pc       = pc_q;
  assign out_port = out_q;
  assign reg_a    = a_q;
  assign reg_b    = b_q;
  assign carry    = carry_q;
  assign halted   = halted_q;

endmodule
